scp_key_conditioner: RTL and testbench
======================================

// Module: scp_key_conditioner
// PURPOSE
//  Front end for the scp_79 sequence checker. Takes the raw, asynchronous g/y/r push-button levels
//  and turns them into clean, single-cycle, mutually exclusive key pulses. Synchronises, debounces
//  and edge-detects each button, and rejects chords (two or more keys at once).
//  Its outputs drive the checker's g/y/r inputs directly. It also exposes an error pulse and a press counter.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive stable samples needed to accept a level change (>=1; board build uses 1_000_000)
//  CNT_W            20  debounce/startup counter width; must hold DEBOUNCE_CYCLES+3
// PORTS
//  clk        in   1  single system clock, all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  g_raw      in   1  raw green button level, asynchronous, bouncy
//  y_raw      in   1  raw yellow button level
//  r_raw      in   1  raw red button level
//  g_p        out  1  one-cycle green key pulse
//  y_p        out  1  one-cycle yellow key pulse
//  r_p        out  1  one-cycle red key pulse
//  key_valid  out  1  high in any cycle where g_p|y_p|r_p is high
//  key_code   out  2  KEY_G=01, KEY_Y=10, KEY_R=11, KEY_NONE=00; valid with key_valid, else 00
//  multi_err  out  1  one-cycle pulse when a chord is rejected
//  press_cnt  out  8  count of accepted key pulses, wraps 255->0
// BEHAVIOUR
//  Reset: every output 0; sync FFs, stable levels and counters 0; FSM enters STARTUP.
//  Per button (debounce cell):
//   - 2-FF synchroniser.
//   - Counter increments while sync2 != stable and clears when they are equal.
//   - stable flips on the edge that sees the DEBOUNCE_CYCLES-th consecutive differing sample.
//   - rise = stable & ~stable_d.
//   - Glitches shorter than DEBOUNCE_CYCLES samples never reach stable.
//  Latency: raw high first sampled at edge E -> stable=1 after edge E+DEBOUNCE_CYCLES+1.
//   The key pulse is registered high for exactly the one cycle after edge E+DEBOUNCE_CYCLES+2.
//  FSM (STARTUP, IDLE, HELD):
//   - STARTUP: counts DEBOUNCE_CYCLES+3 cycles and ignores all rises, then goes to HELD.
//     A button held through reset is therefore never reported.
//   - IDLE, exactly one rise: pulse that key (xx_p, key_valid, key_code), press_cnt+1, go to HELD.
//   - IDLE, >=2 rises in the same cycle: multi_err pulse, no key pulse, press_cnt unchanged, go to HELD.
//   - HELD, any rise: multi_err pulse, no key pulse.
//   - HELD: return to IDLE on the cycle after all three stable levels are 0.
//   - At most one key pulse per press gesture. Key pulses are never back-to-back: there is at least
//     one IDLE cycle between them.
//  Invariants: g_p, y_p, r_p are one-hot or zero. key_valid and multi_err are never high together.
//  Mid-operation rst: on the next edge, all outputs drop, press_cnt=0 and the FSM is in STARTUP.
//   An in-flight pulse is truncated.
//  press_cnt wraps modulo 256 with no flag.
// STRUCTURE
//  scp_key_pkg: KEY_NONE/KEY_G/KEY_Y/KEY_R codes and FSM state encodings (ST_STARTUP, ST_IDLE, ST_HELD).
//  Sub-module scp_debounce (sync + counter + stable + rise), instantiated 3x, parameterised by
//   DEBOUNCE_CYCLES and CNT_W.
//  Top level holds the FSM, startup counter, output registers and press_cnt.
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Reset 3 cycles, then g_raw=1 sampled first at edge 10, held 20 cycles.
//     -> g_p=1, key_code=01, key_valid=1 only after edge 16; press_cnt=1; no further pulse until release.
//  2. Bouncy y_raw: 1 for 2 cycles, 0 for 1, 1 for 3, 0 for 2, then solid 1.
//     -> exactly one y_p, 6 edges after the solid-1 start; press_cnt+1.
//  3. g_raw and r_raw rise on the same edge and are held.
//     -> multi_err one cycle, g_p=r_p=0, press_cnt unchanged; release both -> IDLE.
//  4. Hold r_raw, then raise g_raw 10 cycles later.
//     -> r_p once, then multi_err once 6 edges after the g_raw rise; no g_p.
//  5. r_raw held high across reset and for 30 cycles after.
//     -> no r_p; release r_raw, press again -> one r_p.
//  6. 256 clean g presses. -> press_cnt wraps to 0. Assert rst during the cycle before an expected
//     pulse -> no pulse, press_cnt=0, all outputs 0.

Source files
------------

// File: rtl/scp_key_pkg.sv
// scp_key_pkg: key codes, FSM state encodings and key-code helper for scp_key_conditioner
package scp_key_pkg;
  localparam logic [1:0] KEY_NONE = 2'b00;
  localparam logic [1:0] KEY_G = 2'b01;
  localparam logic [1:0] KEY_Y = 2'b10;
  localparam logic [1:0] KEY_R = 2'b11;
  localparam logic [1:0] ST_STARTUP = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;
  function automatic logic [1:0] key_of(input logic [2:0] k);
    return k[0] ? KEY_G : k[1] ? KEY_Y : k[2] ? KEY_R : KEY_NONE;
  endfunction
endpackage

// File: rtl/scp_debounce.sv
// scp_debounce: 2-FF synchroniser, consecutive-sample debounce and rising-edge detect
module scp_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, stable_q, stable_d, stable_p_q, differ, flip;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    differ = s2_q != stable_q;
    flip = differ && cnt_q == LAST;
    cnt_d = differ && !flip ? cnt_q + CNT_W'(1) : '0;
    stable_d = flip ? s2_q : stable_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      stable_q <= 1'b0;
      stable_p_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      stable_q <= stable_d;
      stable_p_q <= stable_q;
      cnt_q <= cnt_d;
    end
  end
  assign stable_o = stable_q;
  assign rise_o = stable_q & ~stable_p_q;
endmodule

// File: rtl/scp_key_conditioner.sv
// scp_key_conditioner: debounced, chord-rejecting g/y/r key pulse generator with press counter
module scp_key_conditioner
  import scp_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       g_raw,
  input  logic       y_raw,
  input  logic       r_raw,
  output logic       g_p,
  output logic       y_p,
  output logic       r_p,
  output logic       key_valid,
  output logic [1:0] key_code,
  output logic       multi_err,
  output logic [7:0] press_cnt
);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(DEBOUNCE_CYCLES + 2);
  logic [2:0] raw, stable, rise, key_q, key_d;
  logic [1:0] st_q, st_d;
  logic [CNT_W-1:0] boot_q, boot_d;
  logic [7:0] cnt_q, cnt_d;
  logic err_q, err_d, one;
  assign raw = {r_raw, y_raw, g_raw};
  for (genvar i = 0; i < 3; i++) begin : g_db
    scp_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_db (
      .clk(clk),
      .rst(rst),
      .raw_i(raw[i]),
      .stable_o(stable[i]),
      .rise_o(rise[i])
    );
  end
  assign one = rise != 3'b000 && (rise & (rise - 3'd1)) == 3'b000;
  always_comb begin
    st_d = st_q;
    boot_d = boot_q;
    key_d = 3'b000;
    err_d = 1'b0;
    cnt_d = cnt_q;
    if (st_q == ST_STARTUP) begin
      boot_d = boot_q + CNT_W'(1);
      st_d = boot_q == BOOT_LAST ? ST_HELD : ST_STARTUP;
    end else if (st_q == ST_IDLE) begin
      key_d = one ? rise : 3'b000;
      err_d = |rise && !one;
      cnt_d = cnt_q + {7'd0, one};
      st_d = |rise ? ST_HELD : ST_IDLE;
    end else begin
      err_d = |rise;
      st_d = |stable ? ST_HELD : ST_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_STARTUP;
      boot_q <= '0;
      key_q <= 3'b000;
      err_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      st_q <= st_d;
      boot_q <= boot_d;
      key_q <= key_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign g_p = key_q[0];
  assign y_p = key_q[1];
  assign r_p = key_q[2];
  assign key_valid = |key_q;
  assign key_code = key_of(key_q);
  assign multi_err = err_q;
  assign press_cnt = cnt_q;
endmodule

// File: tb/tb_scp_key_conditioner.sv
// tb_scp_key_conditioner: directed and randomized checks of scp_key_conditioner against a behavioural model
module tb_scp_key_conditioner;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b1, g_raw = 1'b0, y_raw = 1'b0, r_raw = 1'b0;
  logic g_p, y_p, r_p, key_valid, multi_err;
  logic [1:0] key_code;
  logic [7:0] press_cnt;
  int total = 0, bad = 0, cyc = 0;
  int seen_g = 0, seen_y = 0, seen_r = 0, seen_err = 0;
  always #5 clk = ~clk;
  scp_key_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .g_raw(g_raw), .y_raw(y_raw), .r_raw(r_raw),
    .g_p(g_p), .y_p(y_p), .r_p(r_p), .key_valid(key_valid),
    .key_code(key_code), .multi_err(multi_err), .press_cnt(press_cnt)
  );
  logic [2:0] s1, s2, stb, stb_p, m_raw, m_rise, e_key;
  logic hist [3][$];
  logic e_err;
  logic [7:0] e_cnt;
  int phase, boot_left, nr;
  function automatic logic flips(input logic q[$], input logic cur);
    if (q.size() != D) return 1'b0;
    foreach (q[k]) if (q[k] == cur) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic [1:0] code_of(input logic [2:0] k);
    return k[0] ? 2'd1 : k[1] ? 2'd2 : k[2] ? 2'd3 : 2'd0;
  endfunction
  // phase: 0 = ignoring rises after reset, 1 = waiting for a key, 2 = keys still down
  always @(posedge clk) begin
    cyc++;
    m_raw = {r_raw, y_raw, g_raw};
    e_key = 3'b000;
    e_err = 1'b0;
    if (rst) begin
      s1 = 3'b000;
      s2 = 3'b000;
      stb = 3'b000;
      stb_p = 3'b000;
      for (int b = 0; b < 3; b++) hist[b].delete();
      phase = 0;
      boot_left = D + 3;
      e_cnt = 8'd0;
    end else begin
      m_rise = stb & ~stb_p;
      nr = $countones(m_rise);
      if (phase == 0) begin
        boot_left--;
        if (boot_left == 0) phase = 2;
      end else if (phase == 1) begin
        if (nr == 1) begin
          e_key = m_rise;
          e_cnt = e_cnt + 8'd1;
        end
        if (nr >= 2) e_err = 1'b1;
        if (nr > 0) phase = 2;
      end else begin
        if (nr > 0) e_err = 1'b1;
        if (stb == 3'b000) phase = 1;
      end
      stb_p = stb;
      for (int b = 0; b < 3; b++) begin
        hist[b].push_back(s2[b]);
        if (hist[b].size() > D) void'(hist[b].pop_front());
        if (flips(hist[b], stb[b])) stb[b] = ~stb[b];
      end
      s2 = s1;
      s1 = m_raw;
    end
  end
  always @(negedge clk) begin
    if (cyc >= 1) begin
      total++;
      if ({r_p, y_p, g_p, key_valid, key_code, multi_err, press_cnt} !==
          {e_key, |e_key, code_of(e_key), e_err, e_cnt}) begin
        bad++;
        $display("FAIL model cyc=%0d got rygp=%b kv=%b code=%0d err=%b cnt=%0d exp rygp=%b kv=%b code=%0d err=%b cnt=%0d",
                 cyc, {r_p, y_p, g_p}, key_valid, key_code, multi_err, press_cnt,
                 e_key, |e_key, code_of(e_key), e_err, e_cnt);
      end
      total++;
      if ($countones({r_p, y_p, g_p}) > 1 || (key_valid && multi_err)) begin
        bad++;
        $display("FAIL invariant cyc=%0d got rygp=%b kv=%b err=%b", cyc, {r_p, y_p, g_p}, key_valid, multi_err);
      end
      seen_g += int'(g_p);
      seen_y += int'(y_p);
      seen_r += int'(r_p);
      seen_err += int'(multi_err);
    end
  end
  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask
  task automatic to_edge(input int k);
    while (cyc < k) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic idle(input int n);
    to_edge(cyc + n);
  endtask
  int s, c0;
  logic pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  int hold [3];
  logic [2:0] lv;
  initial begin
    to_edge(3);
    chk("reset_outputs", int'({g_p, y_p, r_p, key_valid, key_code, multi_err, press_cnt}), 0);
    rst = 1'b0;
    to_edge(9);
    g_raw = 1'b1;
    to_edge(15);
    chk("t1_early", int'(g_p), 0);
    to_edge(16);
    chk("t1_key", int'({g_p, key_valid, key_code}), 'b1101);
    chk("t1_cnt", int'(press_cnt), 1);
    to_edge(17);
    chk("t1_one_cycle", int'(g_p), 0);
    c0 = seen_g;
    to_edge(29);
    g_raw = 1'b0;
    idle(15);
    chk("t1_no_repeat", seen_g - c0, 0);
    c0 = seen_y;
    foreach (pat[k]) begin
      y_raw = pat[k];
      idle(1);
    end
    y_raw = 1'b1;
    s = cyc + 1;
    to_edge(s + 5);
    chk("t2_early", int'(y_p), 0);
    to_edge(s + 6);
    chk("t2_key", int'({y_p, key_code}), 'b110);
    chk("t2_cnt", int'(press_cnt), 2);
    idle(6);
    y_raw = 1'b0;
    idle(15);
    chk("t2_single", seen_y - c0, 1);
    g_raw = 1'b1;
    r_raw = 1'b1;
    s = cyc + 1;
    to_edge(s + 6);
    chk("t3_err", int'({multi_err, g_p, r_p, key_valid}), 'b1000);
    chk("t3_cnt", int'(press_cnt), 2);
    to_edge(s + 7);
    chk("t3_err_once", int'(multi_err), 0);
    to_edge(s + 12);
    g_raw = 1'b0;
    r_raw = 1'b0;
    idle(15);
    c0 = seen_g;
    r_raw = 1'b1;
    s = cyc + 1;
    to_edge(s + 6);
    chk("t4_r_key", int'({r_p, key_code}), 'b111);
    chk("t4_cnt", int'(press_cnt), 3);
    to_edge(s + 9);
    g_raw = 1'b1;
    to_edge(s + 15);
    chk("t4_err_early", int'(multi_err), 0);
    to_edge(s + 16);
    chk("t4_err", int'({multi_err, g_p}), 'b10);
    to_edge(s + 22);
    g_raw = 1'b0;
    r_raw = 1'b0;
    idle(15);
    chk("t4_no_g", seen_g - c0, 0);
    r_raw = 1'b1;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    c0 = seen_r;
    idle(30);
    chk("t5_held_ignored", seen_r - c0, 0);
    chk("t5_cnt", int'(press_cnt), 0);
    r_raw = 1'b0;
    idle(15);
    r_raw = 1'b1;
    s = cyc + 1;
    to_edge(s + 6);
    chk("t5_r_key", int'(r_p), 1);
    chk("t5_cnt_after", int'(press_cnt), 1);
    idle(4);
    r_raw = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(12);
    for (int i = 1; i <= 256; i++) begin
      g_raw = 1'b1;
      idle(8);
      g_raw = 1'b0;
      idle(12);
      if (i == 255) chk("t6_cnt_255", int'(press_cnt), 255);
    end
    chk("t6_wrap", int'(press_cnt), 0);
    g_raw = 1'b1;
    s = cyc + 1;
    to_edge(s + 5);
    rst = 1'b1;
    to_edge(s + 6);
    chk("t6_rst_truncate", int'({g_p, y_p, r_p, key_valid, key_code, multi_err, press_cnt}), 0);
    rst = 1'b0;
    g_raw = 1'b0;
    idle(15);
    lv = 3'b000;
    for (int b = 0; b < 3; b++) hold[b] = int'($urandom_range(1, 14));
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < 3; b++) begin
        hold[b]--;
        if (hold[b] == 0) begin
          lv[b] = ~lv[b];
          hold[b] = int'($urandom_range(1, 14));
        end
      end
      {r_raw, y_raw, g_raw} = lv;
      rst = $urandom_range(0, 499) == 0;
      idle(1);
    end
    rst = 1'b0;
    {r_raw, y_raw, g_raw} = 3'b000;
    idle(15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
